// File: rtl/med_vert_sum.sv
// Vertical stage of the 5x5 binary median: four line buffers of horizontal
// 5-tap counts, a 5-row total, and a registered {median, de, sync} output.
module med_vert_sum #(
  parameter int LINE_W = 640
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sum_in,
  input  logic       de_in,
  input  logic [3:0] pix_in,
  output logic [3:0] pix_out,
  output logic [4:0] vsum,
  output logic       ovf
);

  localparam int CW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(LINE_W - 1);

  logic [2:0] lb0 [LINE_W];
  logic [2:0] lb1 [LINE_W];
  logic [2:0] lb2 [LINE_W];
  logic [2:0] lb3 [LINE_W];

  logic [CW-1:0] col;
  logic [2:0]    lcnt;
  logic          act_d;
  logic          vs_d;
  logic          line_ok;
  logic          full;

  logic          act;
  logic          act_rise;
  logic          act_fall;
  logic          vs_rise;
  logic          wr;
  logic          wv;
  logic          m;
  logic [2:0]    h;
  logic [2:0]    r0, r1, r2, r3;
  logic [4:0]    t;
  logic          unused_pixel;

  assign unused_pixel = pix_in[3];

  always_comb begin
    act      = pix_in[2];
    h        = de_in ? sum_in : '0;
    act_rise = act & ~act_d;
    act_fall = act_d & ~act;
    vs_rise  = pix_in[0] & ~vs_d;
    r0       = lb0[col];
    r1       = lb1[col];
    r2       = lb2[col];
    r3       = lb3[col];
    t        = 5'(h) + 5'(r0) + 5'(r1) + 5'(r2) + 5'(r3);
    // Once the last column has been written, the rest of the line is dropped.
    wr       = act & ~full;
    wv       = wr & de_in & (lcnt == 3'd4);
    m        = wv & (t >= 5'd13);
  end

  // Read-before-write: the shift reads the old contents at col in the same cycle.
  always_ff @(posedge clk) begin
    if (wr) begin
      lb0[col] <= h;
      lb1[col] <= r0;
      lb2[col] <= r1;
      lb3[col] <= r2;
    end
  end

  // act_d resets high so a line already in progress at release is never
  // mistaken for a fresh line and counted towards the four-line history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col     <= '0;
      lcnt    <= '0;
      act_d   <= 1'b1;
      vs_d    <= 1'b0;
      line_ok <= 1'b0;
      full    <= 1'b0;
      ovf     <= 1'b0;
      pix_out <= '0;
      vsum    <= '0;
    end else begin
      act_d   <= act;
      vs_d    <= pix_in[0];
      pix_out <= {m, wv, pix_in[1:0]};
      vsum    <= wv ? t : '0;

      if (act && full) ovf <= 1'b1;

      if (act_rise)      line_ok <= 1'b1;
      else if (act_fall) line_ok <= 1'b0;

      if (vs_rise) begin
        col  <= '0;
        lcnt <= '0;
        full <= 1'b0;
      end else begin
        if (!act) begin
          col  <= '0;
          full <= 1'b0;
        end else if (wr) begin
          if (col == LAST) full <= 1'b1;
          else             col  <= col + CW'(1);
        end
        if (act_fall && line_ok && lcnt != 3'd4) lcnt <= lcnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_med_vert_sum.sv
// Bench for med_vert_sum: randomized lines checked against a line-history
// model of the 5x5 vertical total and median.
module tb_med_vert_sum;

  localparam int LW = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] sum_in = '0;
  logic       de_in = 1'b0;
  logic [3:0] pix_in = '0;
  logic [3:0] pix_out;
  logic [4:0] vsum;
  logic       ovf;
  logic [9:0] obs;
  logic [9:0] e;

  int total = 0;
  int bad   = 0;

  int ls [16];
  bit ld [16];

  typedef int line_t [LW];
  line_t hist[$];
  line_t cur;
  int    nlines  = 0;
  bit    ovf_m   = 1'b0;
  bit    in_line = 1'b0;
  bit    counts  = 1'b0;
  bit    vs_prev = 1'b0;

  assign obs = {pix_out, vsum, ovf};

  med_vert_sum #(.LINE_W(LW)) dut (
    .clk    (clk),
    .rst    (rst),
    .sum_in (sum_in),
    .de_in  (de_in),
    .pix_in (pix_in),
    .pix_out(pix_out),
    .vsum   (vsum),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    nlines = 0;
    hist.delete();
  endfunction

  // Drive one cycle, compute the expected output vector e, step past the edge.
  task automatic cyc(input bit act, input bit vs, input int p);
    int h;
    int t;
    bit wv;
    if (act) begin
      sum_in = 3'(ls[p]);
      de_in  = ld[p];
      pix_in = {1'($urandom), 3'b100};
      if (!in_line) begin
        in_line = 1'b1;
        counts  = 1'b1;
        foreach (cur[i]) cur[i] = 0;
      end
      h  = ld[p] ? ls[p] : 0;
      t  = h;
      wv = ld[p] && (nlines >= 4) && (p < LW);
      if (p < LW) begin
        cur[p] = h;
        for (int k = 0; k < 4 && k < hist.size(); k++) t += hist[k][p];
      end else begin
        ovf_m = 1'b1;
      end
      e = {wv && (t >= 13), wv, 2'b00, wv ? 5'(t) : 5'd0, ovf_m};
    end else begin
      sum_in = 3'($urandom_range(0, 5));
      de_in  = 1'b0;
      pix_in = {1'($urandom), 1'b0, 1'b1, vs};
      if (in_line) begin
        if (counts) begin
          hist.push_front(cur);
          if (hist.size() > 4) void'(hist.pop_back());
          if (nlines < 4) nlines++;
        end
        in_line = 1'b0;
      end
      e = {2'b00, 1'b1, vs, 5'd0, ovf_m};
    end
    if (vs && !vs_prev) model_clear();
    vs_prev = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic frame_start();
    cyc(1'b0, 1'b1, 0);
    cyc(1'b0, 1'b0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs !== 10'd0) begin
      bad++;
      $display("FAIL reset_init got=%h want=%h", obs, 10'd0);
    end
    rst = 1'b0;
    frame_start();
    for (int l = 0; l < 5; l++) begin
      for (int p = 0; p < LW; p++) begin ls[p] = 5; ld[p] = 1'b1; end
      for (int p = 0; p < LW + 4; p++) begin
        cyc(p < LW, 1'b0, p);
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL reset_pre l=%0d p=%0d got=%h want=%h", l, p, obs, e);
        end
      end
    end
    for (int p = 0; p < 4; p++) begin
      cyc(1'b1, 1'b0, p);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reset_line6 p=%0d got=%h want=%h", p, obs, e);
      end
    end
    rst = 1'b1;
    #1;
    total++;
    if (obs !== 10'd0) begin
      bad++;
      $display("FAIL reset_async got=%h want=%h", obs, 10'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    ovf_m   = 1'b0;
    in_line = 1'b1;
    counts  = 1'b0;
    vs_prev = 1'b0;
    for (int p = 4; p < LW + 4; p++) begin
      cyc(p < LW, 1'b0, p);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reset_tail p=%0d got=%h want=%h", p, obs, e);
      end
    end
    for (int l = 0; l < 5; l++) begin
      for (int p = 0; p < LW; p++) begin ls[p] = $urandom_range(0, 5); ld[p] = 1'b1; end
      for (int p = 0; p < LW + 4; p++) begin
        cyc(p < LW, 1'b0, p);
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL reset_post l=%0d p=%0d got=%h want=%h", l, p, obs, e);
        end
        if (p < LW) begin
          total++;
          if (pix_out[2] !== (l == 4)) begin
            bad++;
            $display("FAIL reset_hold l=%0d p=%0d got=%b want=%b", l, p, pix_out[2], l == 4);
          end
        end
      end
    end
  endtask

  task automatic test_all_ones();
    frame_start();
    for (int l = 0; l < 6; l++) begin
      for (int p = 0; p < LW; p++) begin ls[p] = 5; ld[p] = 1'b1; end
      for (int p = 0; p < LW + 4; p++) begin
        cyc(p < LW, 1'b0, p);
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL ones l=%0d p=%0d got=%h want=%h", l, p, obs, e);
        end
        if (p < LW) begin
          total++;
          if (pix_out[2] !== (l >= 4) || vsum !== ((l >= 4) ? 5'd25 : 5'd0) || pix_out[3] !== (l >= 4)) begin
            bad++;
            $display("FAIL ones_const l=%0d p=%0d got=%b/%0d want de=%b", l, p, pix_out[3:2], vsum, l >= 4);
          end
        end
      end
    end
  endtask

  task automatic test_threshold();
    for (int v = 0; v < 2; v++) begin
      frame_start();
      for (int l = 0; l < 5; l++) begin
        for (int p = 0; p < LW; p++) begin ls[p] = (l < 4) ? 3 : v; ld[p] = 1'b1; end
        for (int p = 0; p < LW + 4; p++) begin
          cyc(p < LW, 1'b0, p);
          total++;
          if (obs !== e) begin
            bad++;
            $display("FAIL thresh v=%0d l=%0d p=%0d got=%h want=%h", v, l, p, obs, e);
          end
          if (l == 4 && p < LW) begin
            total++;
            if (vsum !== 5'(12 + v) || pix_out[3] !== v[0]) begin
              bad++;
              $display("FAIL thresh_const v=%0d p=%0d got=%0d/%b want=%0d/%0d", v, p, vsum, pix_out[3], 12 + v, v);
            end
          end
        end
      end
    end
  endtask

  task automatic test_edge_mask();
    bit mid;
    frame_start();
    for (int l = 0; l < 5; l++) begin
      for (int p = 0; p < LW; p++) begin ls[p] = 5; ld[p] = (p >= 2 && p <= 5); end
      for (int p = 0; p < LW + 4; p++) begin
        cyc(p < LW, 1'b0, p);
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL edge l=%0d p=%0d got=%h want=%h", l, p, obs, e);
        end
        if (l == 4 && p < LW) begin
          mid = (p >= 2 && p <= 5);
          total++;
          if (vsum !== (mid ? 5'd25 : 5'd0) || pix_out[2] !== mid) begin
            bad++;
            $display("FAIL edge_const p=%0d got=%0d/%b want de=%b", p, vsum, pix_out[2], mid);
          end
        end
      end
    end
  endtask

  task automatic test_vsync();
    frame_start();
    for (int l = 0; l < 11; l++) begin
      if (l == 6) frame_start();
      for (int p = 0; p < LW; p++) begin
        ls[p] = $urandom_range(0, 5);
        ld[p] = ($urandom_range(0, 3) != 0);
      end
      for (int p = 0; p < LW + 4; p++) begin
        cyc(p < LW, 1'b0, p);
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL vsync l=%0d p=%0d got=%h want=%h", l, p, obs, e);
        end
        if (l >= 6 && p < LW) begin
          total++;
          if (pix_out[2] !== ((l == 10) ? ld[p] : 1'b0)) begin
            bad++;
            $display("FAIL vsync_hold l=%0d p=%0d got=%b", l, p, pix_out[2]);
          end
        end
      end
    end
  endtask

  task automatic test_overflow();
    int n;
    frame_start();
    for (int l = 0; l < 9; l++) begin
      n = (l == 4) ? 10 : LW;
      for (int p = 0; p < n; p++) begin ls[p] = $urandom_range(0, 5); ld[p] = 1'b1; end
      for (int p = 0; p < n + 4; p++) begin
        cyc(p < n, 1'b0, p);
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL ovf l=%0d p=%0d got=%h want=%h", l, p, obs, e);
        end
        if (l == 4 && p >= 8 && p < n) begin
          total++;
          if (ovf !== 1'b1 || pix_out[2] !== 1'b0) begin
            bad++;
            $display("FAIL ovf_const p=%0d got ovf=%b de=%b want ovf=1 de=0", p, ovf, pix_out[2]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_threshold();
    test_edge_mask();
    test_vsync();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
